// File: rtl/cpu_pkg.sv
// Shared CPU types: branch kinds, ARM condition codes, branch-controller states
// and NZCV bit positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        B     = 3'd1,
        CBZ   = 3'd2,
        CBNZ  = 3'd3,
        BCOND = 3'd4
    } branch_kind_t;

    typedef enum logic [3:0] {
        EQ, NE, HS, LO, MI, PL, VS, VC,
        HI, LS, GE, LT, GT, LE, AL, NV
    } cond_t;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } bctl_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/flag_branch_ctrl_if.sv
// EX-stage branch/flag inputs and the fetch redirect handshake.
// master = pipeline/fetch side, slave = branch controller.
interface flag_branch_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic              ex_valid;
    logic              ex_setflags;
    logic              alu_n;
    logic              alu_z;
    logic              alu_c;
    logic              alu_v;
    logic [2:0]        ex_kind;
    logic [3:0]        ex_cond;
    logic              rt_zero;
    logic [ADDR_W-1:0] ex_target;
    logic              redirect_valid;
    logic              redirect_ready;
    logic [ADDR_W-1:0] redirect_pc;
    logic              stall;
    logic              squash;
    logic [3:0]        flags_q;

    modport master (
        output ex_valid, ex_setflags, alu_n, alu_z, alu_c, alu_v,
               ex_kind, ex_cond, rt_zero, ex_target, redirect_ready,
        input  redirect_valid, redirect_pc, stall, squash, flags_q
    );

    modport slave (
        input  ex_valid, ex_setflags, alu_n, alu_z, alu_c, alu_v,
               ex_kind, ex_cond, rt_zero, ex_target, redirect_ready,
        output redirect_valid, redirect_pc, stall, squash, flags_q
    );
endinterface

// File: rtl/cond_eval.sv
// ARM condition-code evaluator: (cond, NZCV) -> condition holds.
// Purely combinational so it can be shared with conditional select.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       taken
);
    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (cond_t'(cond))
            EQ: taken = z;
            NE: taken = !z;
            HS: taken = c;
            LO: taken = !c;
            MI: taken = n;
            PL: taken = !n;
            VS: taken = v;
            VC: taken = !v;
            HI: taken = c && !z;
            LS: taken = !c || z;
            GE: taken = (n == v);
            LT: taken = (n != v);
            GT: taken = !z && (n == v);
            LE: taken = z || (n != v);
            AL: taken = 1'b1;
            NV: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/flag_branch_ctrl.sv
// NZCV flag register and EX-stage branch resolution; a taken branch becomes a
// registered PC redirect held until fetch accepts it.
module flag_branch_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic               clk,
    input  logic               reset,
    flag_branch_ctrl_if.slave  bus
);
    bctl_state_t       state_q, state_d;
    logic [3:0]        flags_q;
    logic [ADDR_W-1:0] pc_q;
    logic              cond_ok;
    logic              taken;
    logic              accept;

    // Branch decision looks at the registered flags only: no same-cycle bypass.
    cond_eval u_cond (
        .cond  (bus.ex_cond),
        .nzcv  (flags_q),
        .taken (cond_ok)
    );

    always_comb begin
        taken = 1'b0;
        case (bus.ex_kind)
            B:       taken = 1'b1;
            CBZ:     taken = bus.rt_zero;
            CBNZ:    taken = !bus.rt_zero;
            BCOND:   taken = cond_ok;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d            = state_q;
        accept             = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;
        bus.squash         = 1'b0;
        case (state_q)
            IDLE: begin
                accept = bus.ex_valid;
                if (accept && taken) state_d = REDIRECT;
            end
            REDIRECT: begin
                bus.redirect_valid = 1'b1;
                bus.stall          = 1'b1;
                if (bus.redirect_ready) begin
                    bus.squash = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            flags_q <= 4'b0000;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept && bus.ex_setflags)
                flags_q <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
            if (accept && taken)
                pc_q <= bus.ex_target;
        end
    end

    assign bus.flags_q     = flags_q;
    assign bus.redirect_pc = pc_q;
endmodule

// File: doc/flag_branch_ctrl.md
# flag_branch_ctrl

Branch-resolution controller for the 64-bit ARM datapath. Owns the architectural NZCV flag register, updates it from the ALU flag outputs, and resolves B, CBZ, CBNZ and B.cond in EX. A taken branch becomes a registered PC redirect, held under a valid/ready handshake with fetch. The front end is stalled and the wrong-path instruction is squashed until fetch accepts the redirect.

## Interface
- ADDR_W, 64, width of the branch target / PC

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- ex_valid  in  1  an instruction is present in EX this cycle
- ex_setflags  in  1  EX instruction writes NZCV (ADDS/SUBS/ANDS)
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flag outputs for the EX instruction; alu_z comes from the 64-bit zero detector on the ALU result
- ex_kind  in  3  branch kind: 0 NONE, 1 B, 2 CBZ, 3 CBNZ, 4 BCOND; 5–7 treated as NONE
- ex_cond  in  4  condition code for BCOND
- rt_zero  in  1  zero-detect of the CBZ/CBNZ register operand
- ex_target  in  ADDR_W  branch target address
- redirect_valid  out  1  redirect request to fetch
- redirect_ready  in  1  fetch accepts the redirect
- redirect_pc  out  ADDR_W  target for fetch
- stall  out  1  freeze PC/IF/ID; EX input is ignored
- squash  out  1  one-cycle pulse: kill the instruction currently in IF/ID
- flags_q  out  4  current {N,Z,C,V}

## Operation
- States: IDLE, REDIRECT.
- An instruction is accepted in a cycle when ex_valid=1 and state=IDLE.

Flags:
- flags_q <= {alu_n,alu_z,alu_c,alu_v} at the edge of any accepted instruction with ex_setflags=1.
- Otherwise flags_q holds its value.

Taken decision (combinational, from flags_q before any same-cycle update):
- B: always taken.
- CBZ: taken if rt_zero=1.
- CBNZ: taken if rt_zero=0.
- BCOND: taken if cond_true(ex_cond, flags_q).
- cond_true table:
  - EQ 0 Z; NE 1 !Z
  - HS 2 C; LO 3 !C
  - MI 4 N; PL 5 !N
  - VS 6 V; VC 7 !V
  - HI 8 C&!Z; LS 9 !C|Z
  - GE A N==V; LT B N!=V
  - GT C !Z&(N==V); LE D Z|(N!=V)
  - AL E, NV F: always true

Transitions:
- IDLE: an accepted instruction that is a taken branch latches redirect_pc <= ex_target; next state REDIRECT.
- IDLE: a not-taken branch or NONE leaves the state in IDLE.
- REDIRECT: redirect_valid=1, stall=1. When redirect_ready=1, next state is IDLE, and squash=1 in that same handshake cycle.
- An instruction that both sets flags and branches updates flags. Its branch is evaluated on the old flags_q.

## Timing
- Reset values: state=IDLE, flags_q=4'b0000, redirect_valid=0, redirect_pc=0, stall=0, squash=0.
- Redirect latency: redirect_valid rises the cycle after the taken branch is in EX.
- Outputs:
  - redirect_valid and stall are Moore outputs of REDIRECT.
  - squash = (state==REDIRECT)&redirect_ready, combinational.
- Holding rule: redirect_pc and redirect_valid stay stable while in REDIRECT until the handshake.
- Back-to-back: the cycle after the handshake is IDLE, so a new taken branch can redirect again one cycle later. Minimum spacing between redirect_valid pulses is 1 idle cycle.
- While in REDIRECT, ex_valid, ex_setflags and the alu_* inputs are ignored; flags_q cannot change.
- Reset asserted mid-REDIRECT: state, redirect_valid and stall drop immediately (asynchronously). The pending redirect is lost.
- Flag-to-BCOND forwarding: a SUBS at edge k is visible to a BCOND in EX in cycle k+1. No same-cycle bypass.

## Structure
- Shared package cpu_pkg holds:
  - enum branch_kind_t (NONE,B,CBZ,CBNZ,BCOND)
  - enum cond_t (EQ..NV)
  - enum bctl_state_t (IDLE,REDIRECT)
  - localparam FLAG_N/Z/C/V bit indices
- Sub-module cond_eval: combinational (cond, nzcv) -> true. It is reused later by conditional select.

## Test plan
- Reset: assert reset mid-cycle with redirect_valid=1 -> all outputs 0 immediately; flags_q=0000.
- SUBS with alu_z=1, then BCOND EQ target 0x400 -> flags_q=0100; redirect_valid=1 with redirect_pc=0x400 one cycle after the branch is in EX.
- CBZ rt_zero=0 and CBNZ rt_zero=1 with target 0x80 -> CBZ not taken (no redirect); CBNZ taken, redirect_pc=0x80.
- Taken B to 0x1000 with redirect_ready held 0 for 3 cycles -> redirect_valid and stall high for 4 cycles. During that window an ADDS with alu_n=1 must not change flags_q. squash=1 only in the handshake cycle.
- Sweep all 16 ex_cond values against flags 1001 (N=1,V=1) -> taken exactly for EQ? no, NE, HS? no: expected taken set {NE, LO, MI, VS, LS, GE, GT, AL, NV}.
- Same-cycle SUBS+BCOND EQ with old Z=0, alu_z=1 -> not taken; flags_q becomes 0100.
